// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end placed directly in front of a word-wide
// DataMemory in the MEM stage.
//  - Loads (lb/lbu/lh/lhu/lw) read in one cycle. The lane is picked from
//    ReadData, extended, and registered into LoadData with a LoadValid pulse.
//  - Word stores write in a single cycle.
//  - Byte/half stores use a two-cycle read-modify-write. Stall is held high
//    during the read cycle.
//  - Byte lanes are big-endian: offset 0 maps to bits [31:24].
// Optional feature macro: MEM_ALIGN_TRAP_EN.
//  - When defined, misaligned half/word accesses are suppressed and reported
//    on Misaligned.
//  - When undefined, Misaligned is tied low and the low address bits are
//    truncated to natural alignment.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ReqValid,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              Stall,
    output logic [DATA_W-1:0] LoadData,
    output logic              LoadValid,
    output logic              Misaligned,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] ReadData
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] merge_reg, merge_next;
    logic [DATA_W-1:0] load_data_reg, load_data_next;
    logic              load_valid_reg, load_valid_next;

    logic [1:0]        offset;
    logic              is_byte, is_half, is_word;
    logic              misaligned_access;

    logic [7:0]        rd_byte [4];
    logic [DATA_W-1:0] merge_data;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [DATA_W-1:0] load_ext;

    logic              mem_read, mem_write, stall;
    logic [DATA_W-1:0] write_data;

    assign offset  = ReqAddr[1:0];
    assign is_byte = (ReqSize == 2'b00);
    assign is_half = (ReqSize == 2'b01);
    assign is_word = ReqSize[1];        // 11 (reserved) behaves as a word

    // DataMemory only ever sees word addresses.
    // The low bits only steer the lanes.
    assign Address = {ReqAddr[ADDR_W-1:2], 2'b00};

`ifdef MEM_ALIGN_TRAP_EN
    assign misaligned_access = (is_half && ReqAddr[0]) ||
                               (is_word && (ReqAddr[1:0] != 2'b00));
`else
    assign misaligned_access = 1'b0;
`endif

    // Per-lane read split and store merge.
    // A half store hits lanes {0,1} or {2,3}, chosen by offset[1].
    // The even lane of a half takes the upper store byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] store_byte;

            assign rd_byte[gi] = ReadData[DATA_W-1-8*gi -: 8];
            assign lane_hit    = is_byte ? (offset == LANE) : (offset[1] == LANE[1]);
            assign store_byte  = (is_byte || LANE[0]) ? ReqWData[7:0] : ReqWData[15:8];
            assign merge_data[DATA_W-1-8*gi -: 8] = lane_hit ? store_byte : rd_byte[gi];
        end
    endgenerate

    // Lane extraction and sign/zero extension of load data.
    always_comb begin
        sel_byte = rd_byte[offset];
        sel_half = offset[1] ? ReadData[15:0] : ReadData[DATA_W-1:16];
        if (is_byte) begin
            load_ext = {{(DATA_W-8){ReqSigned & sel_byte[7]}}, sel_byte};
        end else if (is_half) begin
            load_ext = {{(DATA_W-16){ReqSigned & sel_half[15]}}, sel_half};
        end else begin
            load_ext = ReadData;
        end
    end

    // Next-state logic and memory-side controls.
    always_comb begin
        state_next      = state_reg;
        merge_next      = merge_reg;
        load_data_next  = load_data_reg;
        load_valid_next = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        stall           = 1'b0;
        write_data      = ReqWData;
        case (state_reg)
            IDLE: begin
                if (ReqValid && !misaligned_access) begin
                    if (!ReqWrite) begin
                        mem_read        = 1'b1;
                        load_data_next  = load_ext;
                        load_valid_next = 1'b1;
                    end else if (is_word) begin
                        mem_write = 1'b1;
                    end else begin
                        // Sub-word store: read the word now and write the merge next cycle.
                        mem_read   = 1'b1;
                        stall      = 1'b1;
                        merge_next = merge_data;
                        state_next = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_write  = 1'b1;
                write_data = merge_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset forces the memory strobes low at once.
    // This aborts an in-flight RMW write.
    assign MemRead   = mem_read  & rst_n;
    assign MemWrite  = mem_write & rst_n;
    assign Stall     = stall     & rst_n;
    assign WriteData = write_data;
    assign LoadData  = load_data_reg;
    assign LoadValid = load_valid_reg;

    // State, merge word and load result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            merge_reg      <= '0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            merge_reg      <= merge_next;
            load_data_reg  <= load_data_next;
            load_valid_reg <= load_valid_next;
        end
    end

`ifdef MEM_ALIGN_TRAP_EN
    logic misaligned_reg;

    // One-cycle pulse for each suppressed misaligned request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_reg <= 1'b0;
        end else begin
            misaligned_reg <= (state_reg == IDLE) && ReqValid && misaligned_access;
        end
    end

    assign Misaligned = misaligned_reg;
`else
    assign Misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit.
// A small word-wide DataMemory sits behind the DUT.
// Expected results come from a big-endian byte-array model of memory.
// Follows MEM_ALIGN_TRAP_EN when that macro is defined.
module tb_mem_access_unit;

`ifdef MEM_ALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ReqValid, ReqWrite, ReqSigned;
    logic [1:0]  ReqSize;
    logic [31:0] ReqAddr, ReqWData;
    logic        Stall, LoadValid, Misaligned, MemRead, MemWrite;
    logic [31:0] LoadData, Address, WriteData, ReadData;

    logic [31:0] dmem [16];
    logic [7:0]  ref_mem [64];
    int          wr_count;
    int          n_cmp;
    int          n_err;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
        .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid),
        .Misaligned(Misaligned), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory stand-in: combinational read, synchronous write.
    assign ReadData = dmem[Address[5:2]];
    always @(posedge clk) begin
        if (MemWrite) begin
            dmem[Address[5:2]] <= WriteData;
            wr_count = wr_count + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
    endfunction

    // One request, entered and left 1 time unit after a rising edge.
    task automatic do_access(input bit wr, input logic [1:0] sz, input bit sgn,
                             input logic [31:0] addr, input logic [31:0] wd);
        int          nbytes;
        int          base;
        int          wc0;
        bit          mis;
        bit          sub;
        logic [31:0] exp_ld;
        logic [31:0] exp_wd;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis    = TRAP && ((addr % nbytes) != 0);
        base   = int'(addr) - int'(addr % nbytes);
        sub    = wr && (nbytes < 4) && !mis;
        exp_ld = '0;
        for (int i = 0; i < nbytes; i++) exp_ld = (exp_ld << 8) | 32'(ref_mem[base+i]);
        if (sgn && nbytes < 4 && exp_ld[8*nbytes-1]) exp_ld = exp_ld | ~((32'h1 << (8*nbytes)) - 32'h1);
        if (wr && !mis) begin
            for (int i = 0; i < nbytes; i++) ref_mem[base+i] = 8'(wd >> (8*(nbytes-1-i)));
        end
        exp_wd = ref_word(base & ~3);

        ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sgn;
        ReqAddr = addr; ReqWData = wd;
        wc0 = wr_count;
        @(negedge clk);
        check_val("stall", 32'(Stall), 32'(sub));
        check_val("mem_read", 32'(MemRead), 32'(!mis && (!wr || sub)));
        check_val("mem_write", 32'(MemWrite), 32'(!mis && wr && nbytes == 4));
        check_val("address", Address, {addr[31:2], 2'b00});
        if (wr && !mis && nbytes == 4) check_val("word_wdata", WriteData, wd);
        @(posedge clk); #1;
        if (sub) begin
            @(negedge clk);
            check_val("rmw_write", 32'(MemWrite), 32'd1);
            check_val("rmw_read", 32'(MemRead), 32'd0);
            check_val("rmw_stall", 32'(Stall), 32'd0);
            check_val("rmw_wdata", WriteData, exp_wd);
            @(posedge clk); #1;
        end
        check_val("load_valid", 32'(LoadValid), 32'(!wr && !mis));
        if (!wr && !mis) check_val("load_data", LoadData, exp_ld);
        check_val("misaligned", 32'(Misaligned), 32'(mis));
        check_val("write_count", 32'(wr_count - wc0), 32'(wr && !mis));
        $display("%0t %s size=%0d signed=%0d addr=0x%02h wdata=0x%08h load=0x%08h mis=%0d",
                 $time, wr ? "STORE" : "LOAD ", sz, sgn, addr[7:0], wd, LoadData, Misaligned);
    endtask

    task automatic idle_cycle();
        ReqValid = 1'b0; ReqWrite = 1'($urandom); ReqSize = 2'($urandom);
        ReqAddr = 32'($urandom_range(0, 63)); ReqWData = $urandom;
        @(negedge clk);
        check_val("idle_read", 32'(MemRead), 32'd0);
        check_val("idle_write", 32'(MemWrite), 32'd0);
        check_val("idle_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        check_val("idle_load_valid", 32'(LoadValid), 32'd0);
        $display("%0t IDLE", $time);
    endtask

    initial begin
        int wc0;
        n_cmp = 0; n_err = 0; wr_count = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0;
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b10; ReqSigned = 1'b0;
        ReqAddr = 32'h0; ReqWData = 32'h0;

        // While in reset, the strobes are held low even with a request present.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_load_data", LoadData, 32'h0);
        check_val("rst_load_valid", 32'(LoadValid), 32'd0);
        check_val("rst_misaligned", 32'(Misaligned), 32'd0);
        check_val("rst_mem_read", 32'(MemRead), 32'd0);
        check_val("rst_mem_write", 32'(MemWrite), 32'd0);
        check_val("rst_stall", 32'(Stall), 32'd0);
        $display("%0t RESET", $time);
        rst_n = 1'b1;

        // Basic word store then load.
        do_access(1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF);
        do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        // Preload the rest of memory.
        for (int w = 1; w < 16; w++)
            do_access(1'b1, 2'b10, 1'b0, 32'(4*w), (w == 1 || w == 2) ? 32'h11223344 : $urandom);

        // Sub-word loads from 0xDEADBEEF.
        do_access(1'b0, 2'b00, 1'b1, 32'h1, 32'h0);
        check_val("lb_plan", LoadData, 32'hFFFFFFAD);
        do_access(1'b0, 2'b00, 1'b0, 32'h1, 32'h0);
        do_access(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
        check_val("lh_plan", LoadData, 32'hFFFFBEEF);
        do_access(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);

        // Byte store read-modify-write.
        do_access(1'b1, 2'b00, 1'b0, 32'h6, 32'h000000AA);
        do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        check_val("sb_plan", LoadData, 32'h1122AA44);

        // Reset during RMW_WR aborts the write.
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b01; ReqSigned = 1'b0;
        ReqAddr = 32'h8; ReqWData = 32'h0000BEEF;
        @(negedge clk);
        check_val("abort_stall", 32'(Stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort_rmw_write", 32'(MemWrite), 32'd1);
        check_val("abort_rmw_wdata", WriteData, 32'hBEEF3344);
        wc0 = wr_count;
        rst_n = 1'b0;
        #1;
        check_val("abort_write_drop", 32'(MemWrite), 32'd0);
        check_val("abort_stall_drop", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        check_val("abort_write_count", 32'(wr_count - wc0), 32'd0);
        check_val("abort_mem", dmem[2], 32'h11223344);
        rst_n = 1'b1;
        ReqValid = 1'b0;
        check_val("abort_load_valid", 32'(LoadValid), 32'd0);
        check_val("abort_load_data", LoadData, 32'h0);
        $display("%0t RESET during RMW_WR", $time);
        do_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);

        // Half store read-modify-write.
        do_access(1'b1, 2'b01, 1'b0, 32'h8, 32'h0000BEEF);

        // Back-to-back loads, then an idle cycle.
        do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        do_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        idle_cycle();

        // Misaligned word load.
        do_access(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) idle_cycle();
            do_access(1'($urandom), 2'($urandom), 1'($urandom),
                      32'($urandom_range(0, 63)), $urandom);
        end

        // Final memory image against the model.
        for (int w = 0; w < 16; w++) check_val("mem_final", dmem[w], ref_word(4*w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front-end directly upstream of DataMemory in the MIPS MEM stage. Accepts lb/lbu/lh/lhu/lw/sb/sh/sw requests from the EX/MEM register and drives DataMemory's word-wide Address/WriteData/MemRead/MemWrite. Implements sub-word stores as a 2-cycle read-modify-write with a pipeline stall. Returns sign- or zero-extended load data registered for MEM/WB.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, word width; fixed at 32, byte lanes assume 4 bytes.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ReqValid  in  1  request present this cycle.
ReqWrite  in  1  1 = store, 0 = load.
ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
ReqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
ReqAddr  in  ADDR_W  byte address.
ReqWData  in  DATA_W  store data; byte/half taken from LSBs.
Stall  out  1  combinational; pipeline must hold the request unchanged while high.
LoadData  out  DATA_W  registered extended load result.
LoadValid  out  1  registered 1-cycle pulse qualifying LoadData.
Misaligned  out  1  registered alignment-fault pulse (see Optional Feature).
Address  out  ADDR_W  to DataMemory; always word-aligned ({ReqAddr[31:2],2'b00}).
WriteData  out  DATA_W  to DataMemory.
MemRead  out  1  to DataMemory.
MemWrite  out  1  to DataMemory; high for exactly one cycle per write.
ReadData  in  DATA_W  from DataMemory; valid combinationally in the cycle MemRead is high.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, LoadData=0, LoadValid=0, Misaligned=0, merge register=0. MemRead, MemWrite and Stall are forced to 0 while rst_n is low.
- Byte lanes are big-endian: offset 0 is bits [31:24], offset 3 is bits [7:0]. Half offset 0 is [31:16], offset 2 is [15:0].
- FSM states: IDLE, RMW_WR.
- IDLE, load: MemRead=1, Stall=0. At the clock edge, extract the lane from ReadData, extend per ReqSigned, register it into LoadData, and set LoadValid=1 for one cycle. Latency is 1 cycle. Word loads ignore ReqSigned.
- IDLE, word store: MemWrite=1, WriteData=ReqWData, Stall=0. Single cycle, no state change.
- IDLE, byte/half store: MemRead=1, MemWrite=0, Stall=1. At the edge, the merge register takes ReadData with the target lane replaced by ReqWData[7:0] or [15:0], and the FSM moves to RMW_WR.
- RMW_WR: MemWrite=1, MemRead=0, WriteData=merge register, Address from the held request, Stall=0. FSM returns to IDLE. The pipeline advances at the end of this cycle, so the next request is sampled in IDLE.
- ReqValid=0 in IDLE: MemRead=MemWrite=0, Stall=0, LoadValid drops next cycle.
- Back-to-back loads: LoadValid stays high on consecutive cycles with new data each cycle.
- Reset asserted in RMW_WR: the write is aborted and MemWrite drops immediately, leaving memory unchanged.
- Address bits [1:0] select lanes only; they are never driven to DataMemory.

Optional Feature:
MEM_ALIGN_TRAP_EN.
- Defined: a half access with ReqAddr[0]=1, or a word access with ReqAddr[1:0]!=0, drives MemRead=MemWrite=0 and Stall=0. Misaligned pulses high for 1 cycle on the next edge, and LoadValid is not asserted.
- Undefined: the Misaligned output is tied to 0. Offending low address bits are truncated to natural alignment (half uses ReqAddr[1], word ignores [1:0]), and the access proceeds normally.

Test Plan:
- Reset, then sw addr 0x0 data 0xDEADBEEF, then lw addr 0x0 -> MemWrite pulses 1 cycle; LoadData=0xDEADBEEF with LoadValid the cycle after the lw.
- Mem[0]=0xDEADBEEF; lb addr 0x1 signed -> 0xFFFFFFAD; lbu addr 0x1 -> 0x000000AD; lh addr 0x2 signed -> 0xFFFFBEEF; lhu addr 0x0 -> 0x0000DEAD.
- Mem[4]=0x11223344; sb addr 0x6 data 0x000000AA -> Stall=1 one cycle, then MemWrite with WriteData=0x1122AA44; a following lw addr 0x4 returns 0x1122AA44.
- Mem[8]=0x11223344; sh addr 0x8 data 0xBEEF -> WriteData=0xBEEF3344 in RMW_WR; rst_n pulsed low during RMW_WR in a repeat run -> MemWrite drops immediately, Mem[8] stays 0x11223344, and the FSM returns to IDLE.
- Load sequence lw 0x0, lw 0x4, lw 0x8 on consecutive cycles -> LoadValid high 3 consecutive cycles with matching data and no Stall.
- lw addr 0x2: with MEM_ALIGN_TRAP_EN -> no MemRead, Misaligned=1 for 1 cycle, LoadValid=0; without it -> reads word 0x0, Misaligned=0.
